uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
Frame controller between uart_rx, the ALU and uart_tx. It collects three received bytes in order: operand A, operand B, then opcode. It drives them to the ALU, captures the ALU result and starts one uart_tx transmission of that result. It returns to waiting for the next frame only after uart_tx reports completion.

Parameters:
NB_DATA, 8, width of UART bytes, ALU operands and ALU result
NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte
TIMEOUT_CYCLES, 1000000, inactivity limit in clk cycles (used only with the optional feature)
NB_TIMEOUT, 20, width of the timeout counter; must satisfy 2^NB_TIMEOUT > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; all state updates on the rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_rx_data  in  NB_DATA  byte from uart_rx; valid while i_rxdone=1
i_rxdone  in  1  one-cycle pulse from uart_rx marking a received byte
i_alu_result  in  NB_DATA  combinational ALU output
i_txdone  in  1  one-cycle pulse from uart_tx at the end of its stop bit
o_data_a  out  NB_DATA  registered operand A to the ALU
o_data_b  out  NB_DATA  registered operand B to the ALU
o_op  out  NB_OP  registered opcode to the ALU
o_tx_data  out  NB_DATA  registered byte for uart_tx
o_tx_start  out  1  one-cycle start pulse to uart_tx
o_busy  out  1  1 in every state except S_WAIT_A
o_overrun  out  1  sticky flag for a byte dropped while busy
o_timeout  out  1  one-cycle pulse when a partial frame is aborted

Behaviour:
- Reset (asynchronous, active while i_rst_n=0):
  - state is S_WAIT_A
  - all outputs are 0, including o_data_a, o_data_b, o_op, o_tx_data and all flags
- FSM states: S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_START_TX, S_WAIT_TX.
- S_WAIT_A: on i_rxdone, o_data_a <= i_rx_data, go to S_WAIT_B.
- S_WAIT_B: on i_rxdone, o_data_b <= i_rx_data, go to S_WAIT_OP.
- S_WAIT_OP: on i_rxdone, o_op <= i_rx_data[NB_OP-1:0], go to S_EXEC.
- S_EXEC: one cycle only, so the ALU output settles with the new o_op. Go to S_START_TX.
- S_START_TX: o_tx_data <= i_alu_result; o_tx_start=1 for this single cycle; go to S_WAIT_TX.
- S_WAIT_TX: on i_txdone, go to S_WAIT_A. Waits indefinitely otherwise.
- Latency: i_rxdone of the opcode in cycle n gives o_tx_start=1 in cycle n+2, with o_tx_data valid in the same cycle and held until the next S_START_TX.
- o_tx_start is registered and never asserted for more than one cycle per frame.
- i_txdone outside S_WAIT_TX is ignored.
- Overrun:
  - i_rxdone while in S_EXEC, S_START_TX or S_WAIT_TX drops the byte and sets o_overrun=1.
  - o_overrun clears only on reset.
  - If i_rxdone and i_txdone arrive in the same cycle in S_WAIT_TX, the FSM moves to S_WAIT_A, the byte is dropped and o_overrun is set.
- o_data_a, o_data_b and o_op hold their values between frames; they are overwritten only on acceptance.
- Reset asserted mid-frame aborts immediately. If uart_tx is already running, its later i_txdone is ignored because the FSM is in S_WAIT_A.

Optional Feature:
Macro UART_ALU_TIMEOUT_EN.
- When defined:
  - A counter clears on every accepted byte and counts clk cycles while in S_WAIT_B or S_WAIT_OP.
  - When the count reaches TIMEOUT_CYCLES-1 with no i_rxdone, the FSM goes to S_WAIT_A and o_timeout pulses for 1 cycle. Operand registers keep their values.
  - If i_rxdone occurs in that same cycle, the byte is accepted and the timeout does not fire.
- When not defined: no counter is instantiated, o_timeout is tied to 0, and partial frames wait forever.

Test Plan:
1. Hold i_rst_n=0 for 2 cycles -> all outputs 0, o_busy=0. Release reset -> no change without i_rxdone.
2. Send bytes 0x05, 0x03, 0x20 with an ALU model returning A+B -> o_data_a=0x05, o_data_b=0x03, o_op=0x20; o_tx_start pulses exactly 2 cycles after the third i_rxdone with o_tx_data=0x08; o_busy=1 until i_txdone.
3. After o_tx_start, send byte 0xFF before i_txdone -> byte ignored, o_overrun=1 and stays 1. Then pulse i_txdone and send 0x0A, 0x02, 0x22 (SUB) -> o_tx_data=0x08.
4. Delay i_txdone by 500 cycles, plus a stray i_txdone in S_WAIT_A -> no second o_tx_start, FSM stays in S_WAIT_A.
5. Send 0x11, then pulse i_rst_n low mid-frame -> o_data_a=0, FSM in S_WAIT_A. Next three bytes form a fresh frame.
6. With UART_ALU_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 0x11, then nothing -> o_timeout pulses at cycle 99 after acceptance and o_busy drops to 0. Without the macro, o_timeout stays 0 and o_busy stays 1.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Frame controller between uart_rx, the ALU and uart_tx: collects A, B, opcode, then sends the ALU result.
// Optional partial-frame inactivity abort is enabled with `define UART_ALU_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rxdone,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_txdone,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_START_TX,
    S_WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q, overrun_d;
  logic               timeout_fire;

`ifdef UART_ALU_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
  logic                  counting;

  assign counting     = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
  // Any received byte restarts the count, and it also wins over a same-cycle expiry.
  assign timeout_fire = counting && !i_rxdone &&
                        (cnt_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (counting && !i_rxdone && !timeout_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_timeout = timeout_fire;
`else
  logic [NB_TIMEOUT-1:0] cfg_unused;

  assign cfg_unused   = NB_TIMEOUT'(TIMEOUT_CYCLES);
  assign timeout_fire = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    unique case (state_q)
      S_WAIT_A: begin
        if (i_rxdone) begin
          data_a_d = i_rx_data;
          state_d  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_rxdone) begin
          data_b_d = i_rx_data;
          state_d  = S_WAIT_OP;
        end else if (timeout_fire) begin
          state_d = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (i_rxdone) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else if (timeout_fire) begin
          state_d = S_WAIT_A;
        end
      end
      // The ALU has seen the new opcode for a full cycle here, so capture its result
      // now; that makes o_tx_data valid in the same cycle as the start pulse.
      S_EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = S_START_TX;
      end
      S_START_TX: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_txdone) begin
          state_d = S_WAIT_A;
        end
      end
      default: begin
        state_d = S_WAIT_A;
      end
    endcase
    if (i_rxdone && ((state_q == S_EXEC) || (state_q == S_START_TX) || (state_q == S_WAIT_TX))) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != S_WAIT_A);
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed, table-driven bench for uart_alu_ctrl with a small behavioural ALU.
// Define UART_ALU_TIMEOUT_EN for both files to exercise the inactivity abort.
module tb_uart_alu_ctrl;

  logic       clk;
  logic       rstN;
  logic [7:0] rxData;
  logic       rxDone;
  logic [7:0] aluResult;
  logic       txDone;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic [5:0] op;
  logic [7:0] txData;
  logic       txStart;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int vecCount  = 0;
  int missCount = 0;

  uart_alu_ctrl #(
    .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(100), .NB_TIMEOUT(7)
  ) dut (
    .clk(clk), .i_rst_n(rstN), .i_rx_data(rxData), .i_rxdone(rxDone),
    .i_alu_result(aluResult), .i_txdone(txDone),
    .o_data_a(dataA), .o_data_b(dataB), .o_op(op), .o_tx_data(txData),
    .o_tx_start(txStart), .o_busy(busy), .o_overrun(overrun), .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, otherwise xor.
  always_comb begin
    case (op)
      6'h20:   aluResult = dataA + dataB;
      6'h22:   aluResult = dataA - dataB;
      6'h24:   aluResult = dataA & dataB;
      6'h25:   aluResult = dataA | dataB;
      default: aluResult = dataA ^ dataB;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opByte;
    logic [5:0] expOp;
    logic [7:0] expTx;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rxData = b;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
  endtask

  task automatic pulseTxDone();
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  // Sends a frame and checks the start pulse lands two cycles after the opcode byte.
  task automatic runFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opByte,
                          input logic [5:0] expOp, input logic [7:0] expTx, input string tag);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(opByte);
    checkOutput({tag, " dataA"}, 32'(dataA), 32'(a));
    checkOutput({tag, " dataB"}, 32'(dataB), 32'(b));
    checkOutput({tag, " op"}, 32'(op), 32'(expOp));
    checkOutput({tag, " startEarly"}, 32'(txStart), 32'd0);
    tick();
    checkOutput({tag, " start"}, 32'(txStart), 32'd1);
    checkOutput({tag, " txData"}, 32'(txData), 32'(expTx));
    tick();
    checkOutput({tag, " startOnce"}, 32'(txStart), 32'd0);
    checkOutput({tag, " busyWaitTx"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int startCount;
    int toCount;
    rstN   = 1'b0;
    rxData = 8'h00;
    rxDone = 1'b0;
    txDone = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vecs[1] = '{8'h0A, 8'h02, 8'h22, 6'h22, 8'h08};
    vecs[2] = '{8'hF0, 8'h20, 8'h20, 6'h20, 8'h10};
    vecs[3] = '{8'h03, 8'h05, 8'h22, 6'h22, 8'hFE};
    vecs[4] = '{8'h55, 8'h0F, 8'hE0, 6'h20, 8'h64};
    vecs[5] = '{8'hC3, 8'h3C, 8'h24, 6'h24, 8'h00};

    tick();
    tick();
    checkOutput("rst dataA", 32'(dataA), 32'd0);
    checkOutput("rst dataB", 32'(dataB), 32'd0);
    checkOutput("rst op", 32'(op), 32'd0);
    checkOutput("rst txData", 32'(txData), 32'd0);
    checkOutput("rst start", 32'(txStart), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst overrun", 32'(overrun), 32'd0);
    checkOutput("rst timeout", 32'(timeout), 32'd0);
    rstN = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("idle busy", 32'(busy), 32'd0);
    pulseTxDone();
    tick();
    checkOutput("stray txdone busy", 32'(busy), 32'd0);
    checkOutput("stray txdone start", 32'(txStart), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runFrame(vecs[i].a, vecs[i].b, vecs[i].opByte, vecs[i].expOp, vecs[i].expTx, $sformatf("vec%0d", i));
      pulseTxDone();
      checkOutput($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
      checkOutput($sformatf("vec%0d txHold", i), 32'(txData), 32'(vecs[i].expTx));
    end
    checkOutput("no overrun yet", 32'(overrun), 32'd0);

    runFrame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, "ovr");
    applyStimulus(8'hFF);
    checkOutput("ovr flag", 32'(overrun), 32'd1);
    checkOutput("ovr dataA kept", 32'(dataA), 32'h05);
    checkOutput("ovr busy", 32'(busy), 32'd1);
    pulseTxDone();
    checkOutput("ovr sticky", 32'(overrun), 32'd1);
    runFrame(8'h0A, 8'h02, 8'h22, 6'h22, 8'h08, "postOvr");
    pulseTxDone();
    checkOutput("postOvr sticky", 32'(overrun), 32'd1);

    runFrame(8'h21, 8'h12, 8'h25, 6'h25, 8'h33, "slow");
    startCount = 0;
    for (int i = 0; i < 500; i++) begin
      if (txStart) startCount++;
      tick();
    end
    checkOutput("slow no restart", 32'(startCount), 32'd0);
    checkOutput("slow busy", 32'(busy), 32'd1);
    checkOutput("slow txHold", 32'(txData), 32'h33);
    pulseTxDone();
    pulseTxDone();
    startCount = 0;
    for (int i = 0; i < 5; i++) begin
      if (txStart) startCount++;
      tick();
    end
    checkOutput("slow stray start", 32'(startCount), 32'd0);
    checkOutput("slow idle", 32'(busy), 32'd0);

    applyStimulus(8'h11);
    checkOutput("midRst dataA pre", 32'(dataA), 32'h11);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRst dataA", 32'(dataA), 32'd0);
    checkOutput("midRst busy", 32'(busy), 32'd0);
    checkOutput("midRst overrun", 32'(overrun), 32'd0);
    tick();
    rstN = 1'b1;
    tick();
    runFrame(8'h07, 8'h06, 8'h20, 6'h20, 8'h0D, "fresh");

    applyStimulus(8'h44);
    checkOutput("simul dataA kept", 32'(dataA), 32'h07);
    checkOutput("simul overrun", 32'(overrun), 32'd1);
    rxData = 8'h99;
    rxDone = 1'b1;
    txDone = 1'b1;
    tick();
    rxDone = 1'b0;
    txDone = 1'b0;
    checkOutput("simul idle", 32'(busy), 32'd0);
    checkOutput("simul dropped", 32'(dataA), 32'h07);
    doReset();
    rxData = 8'h99;
    rxDone = 1'b1;
    tick();
    tick();
    rxDone = 1'b0;
    tick();
    rxData = 8'h01;
    rxDone = 1'b1;
    txDone = 1'b1;
    tick();
    rxDone = 1'b0;
    txDone = 1'b0;
    tick();
    tick();
    checkOutput("simul2 waitTx", 32'(busy), 32'd1);
    checkOutput("simul2 clean", 32'(overrun), 32'd0);
    rxDone = 1'b1;
    txDone = 1'b1;
    tick();
    rxDone = 1'b0;
    txDone = 1'b0;
    checkOutput("simul2 idle", 32'(busy), 32'd0);
    checkOutput("simul2 overrun", 32'(overrun), 32'd1);
    checkOutput("simul2 dataA", 32'(dataA), 32'h99);

    doReset();
    applyStimulus(8'h11);
`ifdef UART_ALU_TIMEOUT_EN
    toCount = 0;
    for (int i = 0; i < 98; i++) begin
      tick();
      if (timeout) toCount++;
    end
    checkOutput("to early", 32'(toCount), 32'd0);
    tick();
    checkOutput("to pulse", 32'(timeout), 32'd1);
    checkOutput("to busyAtPulse", 32'(busy), 32'd1);
    tick();
    checkOutput("to pulseEnd", 32'(timeout), 32'd0);
    checkOutput("to idle", 32'(busy), 32'd0);
    checkOutput("to dataA kept", 32'(dataA), 32'h11);
`else
    toCount = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (timeout) toCount++;
    end
    checkOutput("noTo pulses", 32'(toCount), 32'd0);
    checkOutput("noTo busy", 32'(busy), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
